// File: rtl/openfire_mem_arbiter_pkg.sv
// Shared encodings for the OpenFire memory arbiter and its byte-lane steering logic.
package openfire_mem_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Bit 3 is the lowest-addressed byte (big-endian lane order).
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDacc = 2'd1,
        StIacc = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/openfire_lane_steer.sv
// Big-endian byte-lane steering: write replication, byte enables, misalignment check and
// read-lane extraction with zero extension. Purely combinational.
module openfire_lane_steer
    import openfire_mem_arbiter_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned,
    output logic [31:0] rdata_out
);

    always_comb begin
        wdata      = wdata_in;
        be         = BE_WORD;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                wdata = {4{wdata_in[7:0]}};
                be    = BE_BYTE0 >> addr_lo;
            end
            SIZE_HALF: begin
                wdata      = {2{wdata_in[15:0]}};
                be         = addr_lo[1] ? BE_HALF_LO : BE_HALF_HI;
                misaligned = addr_lo[0];
            end
            // Size 3 behaves as a word access.
            default: misaligned = |addr_lo;
        endcase
    end

    always_comb begin
        rdata_out = rdata;
        case (be)
            4'b1000: rdata_out = {24'h0, rdata[31:24]};
            4'b0100: rdata_out = {24'h0, rdata[23:16]};
            4'b0010: rdata_out = {24'h0, rdata[15:8]};
            4'b0001: rdata_out = {24'h0, rdata[7:0]};
            4'b1100: rdata_out = {16'h0, rdata[31:16]};
            4'b0011: rdata_out = {16'h0, rdata[15:0]};
            default: rdata_out = rdata;
        endcase
    end

endmodule

// File: rtl/openfire_mem_arbiter.sv
// Merges the CPU fetch and data ports onto one single-outstanding memory bus, with data
// priority, lane steering, misalignment detection and a bus timeout.
module openfire_mem_arbiter
    import openfire_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    input  logic        imem_re,
    output logic [31:0] imem_data_in,
    output logic        imem_done,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_out,
    input  logic        dmem_we,
    input  logic        dmem_re,
    input  logic [1:0]  dmem_input_sel,
    output logic [31:0] dmem_data_in,
    output logic        dmem_done,
    output logic        dmem_alignment_exception,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_error
);

    localparam bit              TIMEOUT_EN = TIMEOUT_CYCLES != 0;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [1:0]       lo_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [31:0]      imem_data_q;
    logic [31:0]      dmem_data_q;
    logic             imem_done_q;
    logic             dmem_done_q;
    logic             align_exc_q;
    logic             bus_error_q;

    logic        dmem_req;
    logic        busy;
    logic        timed_out;
    logic [1:0]  steer_lo;
    logic [1:0]  steer_size;
    logic [31:0] steer_wdata;
    logic [3:0]  steer_be;
    logic        steer_misaligned;
    logic [31:0] steer_rdata;
    logic [1:0]  unused_imem_lo;

    assign unused_imem_lo = imem_addr[1:0];
    assign dmem_req       = dmem_re | dmem_we;
    assign busy           = (state_q == StDacc) || (state_q == StIacc);
    assign timed_out      = TIMEOUT_EN && busy && !mem_ack && (cnt_q == CNT_LAST);

    // In IDLE the steer sees the live request; during an access it sees the latched one.
    assign steer_lo   = (state_q == StIdle) ? dmem_addr[1:0] : lo_q;
    assign steer_size = (state_q == StIdle) ? dmem_input_sel : size_q;

    openfire_lane_steer u_lane_steer (
        .addr_lo    (steer_lo),
        .size       (steer_size),
        .wdata_in   (dmem_data_out),
        .rdata      (mem_rdata),
        .wdata      (steer_wdata),
        .be         (steer_be),
        .misaligned (steer_misaligned),
        .rdata_out  (steer_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (dmem_req) begin
                    state_d = steer_misaligned ? StDone : StDacc;
                end else if (imem_re) begin
                    state_d = StIacc;
                end
            end
            StDacc, StIacc: begin
                if (mem_ack || timed_out) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req                  = busy;
        mem_we                   = busy & we_q;
        mem_addr                 = addr_q;
        mem_be                   = be_q;
        mem_wdata                = wdata_q;
        imem_data_in             = imem_data_q;
        imem_done                = imem_done_q;
        dmem_data_in             = dmem_data_q;
        dmem_done                = dmem_done_q;
        dmem_alignment_exception = align_exc_q;
        bus_error                = bus_error_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            lo_q        <= '0;
            size_q      <= SIZE_BYTE;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            imem_data_q <= '0;
            dmem_data_q <= '0;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
            align_exc_q <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            cnt_q       <= busy ? cnt_q + CNT_W'(1) : '0;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
            align_exc_q <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (dmem_req && steer_misaligned) begin
                        dmem_done_q <= 1'b1;
                        align_exc_q <= 1'b1;
                        dmem_data_q <= '0;
                    end else if (dmem_req) begin
                        addr_q  <= {dmem_addr[31:2], 2'b00};
                        lo_q    <= dmem_addr[1:0];
                        size_q  <= dmem_input_sel;
                        we_q    <= dmem_we;
                        wdata_q <= steer_wdata;
                        be_q    <= steer_be;
                    end else if (imem_re) begin
                        addr_q <= {imem_addr[31:2], 2'b00};
                        lo_q   <= 2'b00;
                        size_q <= SIZE_WORD;
                        we_q   <= 1'b0;
                        be_q   <= BE_WORD;
                    end
                end
                StDacc: begin
                    if (mem_ack) begin
                        dmem_data_q <= steer_rdata;
                        dmem_done_q <= 1'b1;
                    end else if (timed_out) begin
                        dmem_data_q <= '0;
                        dmem_done_q <= 1'b1;
                        bus_error_q <= 1'b1;
                    end
                end
                StIacc: begin
                    if (mem_ack) begin
                        imem_data_q <= mem_rdata;
                        imem_done_q <= 1'b1;
                    end else if (timed_out) begin
                        imem_data_q <= '0;
                        imem_done_q <= 1'b1;
                        bus_error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_openfire_mem_arbiter.sv
// Directed self-checking bench for openfire_mem_arbiter with a short bus timeout.
module tb_openfire_mem_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_data_in;
    logic        imem_done;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_out;
    logic        dmem_we;
    logic        dmem_re;
    logic [1:0]  dmem_input_sel;
    logic [31:0] dmem_data_in;
    logic        dmem_done;
    logic        dmem_alignment_exception;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_error;

    int n_checks = 0;
    int n_errors = 0;

    openfire_mem_arbiter #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .imem_addr                (imem_addr),
        .imem_re                  (imem_re),
        .imem_data_in             (imem_data_in),
        .imem_done                (imem_done),
        .dmem_addr                (dmem_addr),
        .dmem_data_out            (dmem_data_out),
        .dmem_we                  (dmem_we),
        .dmem_re                  (dmem_re),
        .dmem_input_sel           (dmem_input_sel),
        .dmem_data_in             (dmem_data_in),
        .dmem_done                (dmem_done),
        .dmem_alignment_exception (dmem_alignment_exception),
        .mem_req                  (mem_req),
        .mem_we                   (mem_we),
        .mem_addr                 (mem_addr),
        .mem_be                   (mem_be),
        .mem_wdata                (mem_wdata),
        .mem_rdata                (mem_rdata),
        .mem_ack                  (mem_ack),
        .bus_error                (bus_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        imem_addr      = '0;
        imem_re        = 1'b0;
        dmem_addr      = '0;
        dmem_data_out  = '0;
        dmem_we        = 1'b0;
        dmem_re        = 1'b0;
        dmem_input_sel = 2'd0;
        mem_rdata      = '0;
        mem_ack        = 1'b0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dmem_data", dmem_data_in, 0);
        check("rst_imem_done", 32'(imem_done), 0);
        reset = 1'b1;
        tick();

        // Aligned word load, ack after two wait cycles.
        dmem_re = 1'b1; dmem_addr = 'h100; dmem_input_sel = 2'd2;
        tick();
        check("wl_req", 32'(mem_req), 1);
        check("wl_be", 32'(mem_be), 'hF);
        check("wl_addr", mem_addr, 'h100);
        check("wl_we", 32'(mem_we), 0);
        tick();
        tick();
        check("wl_req_wait", 32'(mem_req), 1);
        check("wl_done_early", 32'(dmem_done), 0);
        mem_ack = 1'b1; mem_rdata = 'hDEADBEEF;
        tick();
        mem_ack = 1'b0; dmem_re = 1'b0;
        check("wl_done", 32'(dmem_done), 1);
        check("wl_data", dmem_data_in, 'hDEADBEEF);
        check("wl_req_off", 32'(mem_req), 0);
        tick();
        check("wl_done_clr", 32'(dmem_done), 0);
        check("wl_data_hold", dmem_data_in, 'hDEADBEEF);

        // Byte store at 0x203.
        dmem_we = 1'b1; dmem_addr = 'h203; dmem_data_out = 'hA5; dmem_input_sel = 2'd0;
        tick();
        check("bs_be", 32'(mem_be), 'h1);
        check("bs_wdata", mem_wdata, 'hA5A5A5A5);
        check("bs_we", 32'(mem_we), 1);
        check("bs_addr", mem_addr, 'h200);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; dmem_we = 1'b0;
        check("bs_done", 32'(dmem_done), 1);
        tick();

        // Halfword store at 0x200: upper lanes.
        dmem_we = 1'b1; dmem_addr = 'h200; dmem_data_out = 'h0000BEEF; dmem_input_sel = 2'd1;
        tick();
        check("hs_be", 32'(mem_be), 'hC);
        check("hs_wdata", mem_wdata, 'hBEEFBEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; dmem_we = 1'b0;
        tick();

        // Halfword load at 0x202 -> low half of the word.
        dmem_re = 1'b1; dmem_addr = 'h202; dmem_input_sel = 2'd1;
        tick();
        check("hl_be", 32'(mem_be), 'h3);
        check("hl_we", 32'(mem_we), 0);
        mem_ack = 1'b1; mem_rdata = 'h11223344;
        tick();
        mem_ack = 1'b0; dmem_re = 1'b0;
        check("hl_data", dmem_data_in, 'h00003344);
        tick();

        // Byte load at 0x201 -> lane [23:16].
        dmem_re = 1'b1; dmem_addr = 'h201; dmem_input_sel = 2'd0;
        tick();
        check("bl_be", 32'(mem_be), 'h4);
        mem_ack = 1'b1; mem_rdata = 'h11223344;
        tick();
        mem_ack = 1'b0; dmem_re = 1'b0;
        check("bl_data", dmem_data_in, 'h22);
        tick();

        // Misaligned halfword load at 0x101: no bus cycle.
        dmem_re = 1'b1; dmem_addr = 'h101; dmem_input_sel = 2'd1;
        tick();
        dmem_re = 1'b0;
        check("mis_req", 32'(mem_req), 0);
        check("mis_done", 32'(dmem_done), 1);
        check("mis_exc", 32'(dmem_alignment_exception), 1);
        check("mis_data", dmem_data_in, 0);
        tick();
        check("mis_exc_clr", 32'(dmem_alignment_exception), 0);
        check("mis_done_clr", 32'(dmem_done), 0);

        // Misaligned word store at 0x102.
        dmem_we = 1'b1; dmem_addr = 'h102; dmem_input_sel = 2'd2;
        tick();
        dmem_we = 1'b0;
        check("misw_exc", 32'(dmem_alignment_exception), 1);
        check("misw_req", 32'(mem_req), 0);
        tick();

        // Simultaneous fetch and load: data first.
        imem_re = 1'b1; imem_addr = 'h400;
        dmem_re = 1'b1; dmem_addr = 'h104; dmem_input_sel = 2'd2;
        tick();
        check("sim_d_addr", mem_addr, 'h104);
        check("sim_d_req", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 'h55667788;
        tick();
        mem_ack = 1'b0; dmem_re = 1'b0;
        check("sim_d_done", 32'(dmem_done), 1);
        check("sim_i_done_n", 32'(imem_done), 0);
        check("sim_d_data", dmem_data_in, 'h55667788);
        tick();
        check("sim_idle_req", 32'(mem_req), 0);
        check("sim_d_done_clr", 32'(dmem_done), 0);
        tick();
        check("sim_i_req", 32'(mem_req), 1);
        check("sim_i_addr", mem_addr, 'h400);
        check("sim_i_be", 32'(mem_be), 'hF);
        mem_ack = 1'b1; mem_rdata = 'hCAFEF00D;
        tick();
        mem_ack = 1'b0; imem_re = 1'b0;
        check("sim_i_done", 32'(imem_done), 1);
        check("sim_i_data", imem_data_in, 'hCAFEF00D);
        check("sim_d_done_n", 32'(dmem_done), 0);
        tick();
        check("sim_i_done_clr", 32'(imem_done), 0);

        // Fetch timeout with no ack.
        imem_re = 1'b1; imem_addr = 'h500;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_req_%0d", i), 32'(mem_req), 1);
            check($sformatf("to_berr_%0d", i), 32'(bus_error), 0);
        end
        tick();
        imem_re = 1'b0;
        check("to_req_off", 32'(mem_req), 0);
        check("to_berr", 32'(bus_error), 1);
        check("to_i_done", 32'(imem_done), 1);
        check("to_i_data", imem_data_in, 0);
        tick();
        check("to_berr_clr", 32'(bus_error), 0);

        // Reset in the middle of a data access, late ack ignored.
        dmem_re = 1'b1; dmem_addr = 'h108; dmem_input_sel = 2'd2;
        tick();
        check("rm_req", 32'(mem_req), 1);
        reset = 1'b0; dmem_re = 1'b0;
        tick();
        check("rm_req_off", 32'(mem_req), 0);
        check("rm_d_data", dmem_data_in, 0);
        check("rm_be", 32'(mem_be), 0);
        check("rm_addr", mem_addr, 0);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 'h99999999;
        tick();
        mem_ack = 1'b0;
        check("rm_late_done", 32'(dmem_done), 0);
        check("rm_late_req", 32'(mem_req), 0);
        check("rm_late_data", dmem_data_in, 0);
        tick();
        check("rm_idle_done", 32'(dmem_done), 0);

        // FSM is back in IDLE and accepts a fetch.
        imem_re = 1'b1; imem_addr = 'h600;
        tick();
        check("rm_fetch_req", 32'(mem_req), 1);
        check("rm_fetch_addr", mem_addr, 'h600);
        mem_ack = 1'b1; mem_rdata = 'h12345678;
        tick();
        mem_ack = 1'b0; imem_re = 1'b0;
        check("rm_fetch_data", imem_data_in, 'h12345678);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/openfire_mem_arbiter.md
Name: openfire_mem_arbiter

Overview:
- Sits directly downstream of the CPU core's memory ports.
- Merges the instruction-fetch port (imem_*) and the data port (dmem_*) onto one external single-outstanding memory bus.
- Performs big-endian byte-lane steering for byte, halfword and word accesses, and detects misaligned data accesses.
- Completes a hung bus access through a timeout.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait for mem_ack before aborting; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
imem_addr  in  32  fetch address from CPU
imem_re  in  1  fetch request; level, held until imem_done
imem_data_in  out  32  fetched instruction (name as seen by CPU)
imem_done  out  1  one-cycle fetch completion pulse
dmem_addr  in  32  data address from CPU
dmem_data_out  in  32  store data from CPU, right-justified
dmem_we  in  1  store request; level, held until dmem_done
dmem_re  in  1  load request; level, held until dmem_done
dmem_input_sel  in  2  0=byte, 1=halfword, 2=word; 3 treated as word
dmem_data_in  out  32  load data to CPU, zero-extended
dmem_done  out  1  one-cycle data completion pulse
dmem_alignment_exception  out  1  pulse coincident with dmem_done on misaligned access
mem_req  out  1  external bus request
mem_we  out  1  external write enable
mem_addr  out  32  external word address, bits[1:0] forced 0
mem_be  out  4  byte enables, bit3 = byte lane [31:24] (lowest address)
mem_wdata  out  32  lane-steered write data
mem_rdata  in  32  external read data, valid when mem_ack=1
mem_ack  in  1  external completion, one cycle
bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE. All outputs 0, including data outputs and mem_be. Timeout counter 0. An access in flight is abandoned; a late mem_ack after reset is ignored.
- FSM states: IDLE, DACC, IACC, DONE.
- IDLE: dmem request (dmem_re|dmem_we) has priority over imem_re.
  - Data access, aligned: latch addr/we/size/wdata, go to DACC.
  - Data access, misaligned (halfword with addr[0]=1; word with addr[1:0]!=0): no bus cycle. Next cycle dmem_done=1, dmem_alignment_exception=1, dmem_data_in=0; go to DONE.
  - Fetch only: latch addr, go to IACC.
- dmem_we and dmem_re together: treated as store.
- DACC/IACC: mem_req=1, registered outputs stable for the whole access; counter increments each cycle.
  - On mem_ack: register data. Assert dmem_done or imem_done for exactly one cycle on the next clock. Go to DONE.
  - If counter reaches TIMEOUT_CYCLES without ack: drop mem_req. Pulse bus_error and the matching done with data 0. Go to DONE.
- DONE: one turnaround cycle; requests ignored. Go to IDLE. The CPU deasserts its request in this cycle.
- Minimum latency: request sampled cycle N, mem_req at N+1, ack at N+1 earliest, done at N+2. Minimum 3-cycle access period including DONE.
- Byte-lane steering (write):
  - byte: wdata = {4{d[7:0]}}, be = 4'b1000 >> addr[1:0]
  - halfword: wdata = {2{d[15:0]}}, be = addr[1] ? 4'b0011 : 4'b1100
  - word: be = 4'b1111
- Byte-lane steering (read): select the lane matching be, right-justify, zero-extend. Fetches always use be=4'b1111, mem_we=0.
- Simultaneous imem and dmem requests: data is served first. The fetch is served after DONE if still held.
- mem_ack outside DACC/IACC is ignored.
- Outputs imem_data_in and dmem_data_in hold their last value until the next completion.

Decomposition:
- Shared package: size encodings (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2), FSM state encodings, byte-enable constants.
- Natural sub-module: openfire_lane_steer. This is combinational write-data/byte-enable generation plus read extraction, reused later by a data cache.

Test Plan:
- Aligned word load: dmem_re, addr 0x100, sel 2, memory returns 0xDEADBEEF after 2 wait cycles -> mem_be=1111, mem_addr=0x100, dmem_done one cycle after ack, dmem_data_in=0xDEADBEEF.
- Byte store: addr 0x203, data 0x000000A5, sel 0 -> mem_be=0001, mem_wdata=0xA5A5A5A5, mem_we=1. Halfword load at 0x202 with rdata 0x11223344 -> dmem_data_in=0x00003344.
- Misaligned halfword load at 0x101 -> no mem_req. dmem_done and dmem_alignment_exception high together 1 cycle after request, data 0.
- imem_re and dmem_re asserted same cycle -> data access issued first. Fetch mem_req follows after one DONE cycle. Each done pulses exactly once.
- No mem_ack, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles then low. bus_error and imem_done pulse together, imem_data_in=0.
- reset=0 asserted mid DACC, then mem_ack arrives after release -> all outputs 0, no done pulse, FSM IDLE.
